// File: rtl/emesh_pkg.sv
// Shared emesh types: datamode encodings, transaction and response records.
package emesh_pkg;

  localparam int COORD_W = 12;

  localparam logic [1:0] DM_BYTE  = 2'd0;
  localparam logic [1:0] DM_HALF  = 2'd1;
  localparam logic [1:0] DM_WORD  = 2'd2;
  localparam logic [1:0] DM_DWORD = 2'd3;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } rsp_state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } emesh_txn_t;

  typedef struct packed {
    logic [31:0] dstaddr;
    logic [3:0]  ctrlmode;
    logic [1:0]  datamode;
    logic [31:0] lo;
    logic [31:0] hi;
  } emesh_rsp_t;

  // Right-align the addressed byte/halfword lane, zero-extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  dm,
                                               input logic [1:0]  off);
    case (dm)
      DM_BYTE: return {24'd0, word[{off, 3'b000} +: 8]};
      DM_HALF: return {16'd0, (off[1] ? word[31:16] : word[15:0])};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/emesh_sync_fifo.sv
// Synchronous FIFO whose head is read straight from the storage flops.
module emesh_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         eclk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge eclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A push while full is only legal alongside a pop, which frees the slot it reuses.
  always_ff @(posedge eclk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(D));
  assign empty = (count_reg == '0);

  assert property (@(posedge eclk) disable iff (!reset_n) !(push && full && !pop));
  assert property (@(posedge eclk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/emesh_rd_responder.sv
// Emesh target endpoint: local register file, reads answered as emesh writes
// to the requester's srcaddr through an in-order response FIFO.
module emesh_rd_responder
  import emesh_pkg::*;
#(
  parameter logic [COORD_W-1:0] COORD = 12'h810,
  parameter int                 AW    = 6,
  parameter int                 FD    = 4
) (
  input  logic        eclk,
  input  logic        reset_n,
  input  logic        access_in,
  input  logic        write_in,
  input  logic [1:0]  datamode_in,
  input  logic [3:0]  ctrlmode_in,
  input  logic [31:0] dstaddr_in,
  input  logic [31:0] srcaddr_in,
  input  logic [31:0] data_in,
  output logic        wr_wait_out,
  output logic        rd_wait_out,
  output logic        access_out,
  output logic        write_out,
  output logic [1:0]  datamode_out,
  output logic [3:0]  ctrlmode_out,
  output logic [31:0] dstaddr_out,
  output logic [31:0] srcaddr_out,
  output logic [31:0] data_out,
  input  logic        wr_wait_in
);

  localparam int DEPTH = 1 << AW;

  rsp_state_t    state_reg, state_next;
  logic [AW-1:0] clr_reg, clr_next;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  emesh_txn_t    txn;
  emesh_rsp_t    rsp_new, rsp_head, rsp_shown;
  logic          hit, wr_hit, dword;
  logic [AW-1:0] idx, lo_idx, hi_idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wr_lo, rd_lo, rd_hi;
  logic          unused_addr_bits;

  always_ff @(posedge eclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
      clr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      clr_reg   <= clr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    clr_next    = clr_reg;
    wr_wait_out = 1'b1;
    rd_wait_out = 1'b1;
    case (state_reg)
      ST_INIT: begin
        clr_next = clr_reg + AW'(1);
        if (clr_reg == {AW{1'b1}}) state_next = ST_RUN;
      end
      default: begin
        wr_wait_out = 1'b0;
        rd_wait_out = fifo_full;
      end
    endcase
  end

  assign txn = '{write_in, datamode_in, ctrlmode_in, dstaddr_in, srcaddr_in, data_in};
  assign unused_addr_bits = ^txn.dstaddr[19:AW+2];

  assign hit    = (txn.dstaddr[31:32-COORD_W] == COORD);
  assign wr_hit = access_in & txn.write & ~wr_wait_out & hit;
  assign dword  = (txn.datamode == DM_DWORD);
  assign off    = txn.dstaddr[1:0];
  assign idx    = txn.dstaddr[AW+1:2];
  assign lo_idx = dword ? {idx[AW-1:1], 1'b0} : idx;
  assign hi_idx = {idx[AW-1:1], 1'b1};

  always_comb begin
    be    = 4'b1111;
    wr_lo = txn.data;
    case (txn.datamode)
      DM_BYTE: begin
        be    = 4'b0001 << off;
        wr_lo = {4{txn.data[7:0]}};
      end
      DM_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wr_lo = {2{txn.data[15:0]}};
      end
      default: ;
    endcase
  end

  // Register file split into byte lanes so partial writes need no read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    always_ff @(posedge eclk) begin
      if (state_reg == ST_INIT) begin
        lane_mem[clr_reg] <= '0;
      end else if (wr_hit) begin
        if (be[gi]) lane_mem[lo_idx] <= wr_lo[8*gi +: 8];
        if (dword)  lane_mem[hi_idx] <= txn.srcaddr[8*gi +: 8];
      end
    end
    assign rd_lo[8*gi +: 8] = lane_mem[lo_idx];
    assign rd_hi[8*gi +: 8] = lane_mem[hi_idx];
  end

  assign rsp_new.dstaddr  = txn.srcaddr;
  assign rsp_new.ctrlmode = txn.ctrlmode;
  assign rsp_new.datamode = txn.datamode;
  assign rsp_new.lo       = lane_extract(rd_lo, txn.datamode, off);
  assign rsp_new.hi       = dword ? rd_hi : 32'd0;

  assign fifo_push = access_in & ~txn.write & ~rd_wait_out & hit;
  assign fifo_pop  = ~fifo_empty & ~wr_wait_in;

  emesh_sync_fifo #(
    .W ($bits(emesh_rsp_t)),
    .D (FD)
  ) u_fifo (
    .eclk    (eclk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (rsp_new),
    .pop     (fifo_pop),
    .head    (rsp_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rsp_shown    = fifo_empty ? '0 : rsp_head;
  assign access_out   = ~fifo_empty;
  assign write_out    = ~fifo_empty;
  assign datamode_out = rsp_shown.datamode;
  assign ctrlmode_out = rsp_shown.ctrlmode;
  assign dstaddr_out  = rsp_shown.dstaddr;
  assign srcaddr_out  = rsp_shown.hi;
  assign data_out     = rsp_shown.lo;

endmodule

// File: tb/tb_emesh_rd_responder.sv
// Directed bench for emesh_rd_responder: init sweep, lane access, backpressure,
// filtering and reset during traffic.
module tb_emesh_rd_responder;
  import emesh_pkg::*;

  logic        eclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        access_in = 1'b0;
  logic        write_in = 1'b0;
  logic [1:0]  datamode_in = 2'd0;
  logic [3:0]  ctrlmode_in = 4'd0;
  logic [31:0] dstaddr_in = 32'd0;
  logic [31:0] srcaddr_in = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic        wr_wait_in = 1'b0;
  logic        wr_wait_out, rd_wait_out, access_out, write_out;
  logic [1:0]  datamode_out;
  logic [3:0]  ctrlmode_out;
  logic [31:0] dstaddr_out, srcaddr_out, data_out;

  int vec_count = 0;
  int err_count = 0;

  always #5 eclk = ~eclk;

  emesh_rd_responder dut (
    .eclk         (eclk),
    .reset_n      (reset_n),
    .access_in    (access_in),
    .write_in     (write_in),
    .datamode_in  (datamode_in),
    .ctrlmode_in  (ctrlmode_in),
    .dstaddr_in   (dstaddr_in),
    .srcaddr_in   (srcaddr_in),
    .data_in      (data_in),
    .wr_wait_out  (wr_wait_out),
    .rd_wait_out  (rd_wait_out),
    .access_out   (access_out),
    .write_out    (write_out),
    .datamode_out (datamode_out),
    .ctrlmode_out (ctrlmode_out),
    .dstaddr_out  (dstaddr_out),
    .srcaddr_out  (srcaddr_out),
    .data_out     (data_out),
    .wr_wait_in   (wr_wait_in)
  );

  // Called at a negedge; presents one transaction for exactly one rising edge.
  task automatic put(input logic w, input logic [1:0] dm, input logic [31:0] dst,
                     input logic [31:0] src, input logic [31:0] dat);
    access_in   = 1'b1;
    write_in    = w;
    datamode_in = dm;
    dstaddr_in  = dst;
    srcaddr_in  = src;
    data_in     = dat;
    $display("txn %s dm=%0d dst=%h src=%h data=%h", w ? "wr" : "rd", dm, dst, src, dat);
    @(negedge eclk);
    access_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge eclk);
    vec_count++;
    if (access_out !== 1'b0 || write_out !== 1'b0) begin
      err_count++;
      $display("FAIL reset_access: got %b/%b want 0/0", access_out, write_out);
    end
    vec_count++;
    if ({datamode_out, ctrlmode_out, dstaddr_out, srcaddr_out, data_out} !== 102'd0) begin
      err_count++;
      $display("FAIL reset_payload: got %h %h %h want 0", dstaddr_out, srcaddr_out, data_out);
    end
    vec_count++;
    if (wr_wait_out !== 1'b1 || rd_wait_out !== 1'b1) begin
      err_count++;
      $display("FAIL reset_waits: got %b/%b want 1/1", wr_wait_out, rd_wait_out);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge eclk);
      vec_count++;
      if (wr_wait_out !== (i < 64) || rd_wait_out !== (i < 64)) begin
        err_count++;
        $display("FAIL init_waits cycle %0d: got %b/%b want %b", i, wr_wait_out, rd_wait_out, (i < 64));
      end
    end
    put(1'b0, DM_WORD, 32'h8100_0044, 32'h8080_0004, 32'd0);
    vec_count++;
    if (access_out !== 1'b1 || data_out !== 32'd0 || dstaddr_out !== 32'h8080_0004) begin
      err_count++;
      $display("FAIL init_cleared: got acc=%b data=%h dst=%h want 1 0 80800004", access_out, data_out, dstaddr_out);
    end
  endtask

  task automatic test_word();
    put(1'b1, DM_WORD, 32'h8100_0010, 32'd0, 32'hDEAD_BEEF);
    ctrlmode_in = 4'hA;
    put(1'b0, DM_WORD, 32'h8100_0010, 32'h8080_0000, 32'd0);
    ctrlmode_in = 4'h0;
    vec_count++;
    if (access_out !== 1'b1 || write_out !== 1'b1) begin
      err_count++;
      $display("FAIL word_valid: got %b/%b want 1/1", access_out, write_out);
    end
    vec_count++;
    if (dstaddr_out !== 32'h8080_0000 || data_out !== 32'hDEAD_BEEF || srcaddr_out !== 32'd0) begin
      err_count++;
      $display("FAIL word_payload: got %h %h %h want 80800000 deadbeef 0", dstaddr_out, data_out, srcaddr_out);
    end
    vec_count++;
    if (datamode_out !== DM_WORD || ctrlmode_out !== 4'hA) begin
      err_count++;
      $display("FAIL word_modes: got dm=%0d cm=%h want 2 a", datamode_out, ctrlmode_out);
    end
    @(negedge eclk);
    vec_count++;
    if (access_out !== 1'b0) begin
      err_count++;
      $display("FAIL word_single: got access_out=%b want 0", access_out);
    end
  endtask

  task automatic test_byte_dword();
    put(1'b0, DM_BYTE, 32'h8100_0012, 32'h8080_0010, 32'd0);
    vec_count++;
    if (data_out !== 32'h0000_00AD || datamode_out !== DM_BYTE) begin
      err_count++;
      $display("FAIL byte_read: got %h dm=%0d want 000000ad dm=0", data_out, datamode_out);
    end
    put(1'b0, DM_HALF, 32'h8100_0012, 32'h8080_0010, 32'd0);
    vec_count++;
    if (data_out !== 32'h0000_DEAD) begin
      err_count++;
      $display("FAIL half_read: got %h want 0000dead", data_out);
    end
    put(1'b1, DM_BYTE, 32'h8100_0011, 32'd0, 32'h0000_0055);
    put(1'b0, DM_WORD, 32'h8100_0010, 32'h8080_0010, 32'd0);
    vec_count++;
    if (data_out !== 32'hDEAD_55EF) begin
      err_count++;
      $display("FAIL byte_write: got %h want dead55ef", data_out);
    end
    put(1'b1, DM_DWORD, 32'h8100_0020, 32'h1111_2222, 32'h3333_4444);
    put(1'b0, DM_DWORD, 32'h8100_0020, 32'h8080_0018, 32'd0);
    vec_count++;
    if (data_out !== 32'h3333_4444 || srcaddr_out !== 32'h1111_2222) begin
      err_count++;
      $display("FAIL dword_read: got %h/%h want 33334444/11112222", data_out, srcaddr_out);
    end
    put(1'b0, DM_DWORD, 32'h8100_0024, 32'h8080_0018, 32'd0);
    vec_count++;
    if (data_out !== 32'h3333_4444 || srcaddr_out !== 32'h1111_2222) begin
      err_count++;
      $display("FAIL dword_odd: got %h/%h want 33334444/11112222", data_out, srcaddr_out);
    end
    put(1'b0, DM_WORD, 32'h8100_0024, 32'h8080_0018, 32'd0);
    vec_count++;
    if (data_out !== 32'h1111_2222 || srcaddr_out !== 32'd0) begin
      err_count++;
      $display("FAIL dword_upper: got %h/%h want 11112222/0", data_out, srcaddr_out);
    end
    put(1'b0, DM_WORD, 32'h8100_0110, 32'h8080_0018, 32'd0);
    vec_count++;
    if (data_out !== 32'hDEAD_55EF) begin
      err_count++;
      $display("FAIL alias_read: got %h want dead55ef", data_out);
    end
  endtask

  task automatic test_backpressure();
    int  got;
    int  cyc;
    logic acc;
    for (int i = 0; i < 5; i++)
      put(1'b1, DM_WORD, 32'h8100_0080 + 32'(4 * i), 32'd0, 32'hA000_0000 + 32'(i));
    wr_wait_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (rd_wait_out !== 1'b0) begin
        err_count++;
        $display("FAIL bp_fill %0d: got rd_wait_out=%b want 0", i, rd_wait_out);
      end
      put(1'b0, DM_WORD, 32'h8100_0080 + 32'(4 * i), 32'h9000_0000 + 32'(i), 32'd0);
    end
    access_in   = 1'b1;
    write_in    = 1'b0;
    datamode_in = DM_WORD;
    dstaddr_in  = 32'h8100_0090;
    srcaddr_in  = 32'h9000_0004;
    $display("txn rd held dst=%h src=%h", dstaddr_in, srcaddr_in);
    repeat (3) begin
      @(negedge eclk);
      vec_count++;
      if (rd_wait_out !== 1'b1 || access_out !== 1'b1 || dstaddr_out !== 32'h9000_0000 || data_out !== 32'hA000_0000) begin
        err_count++;
        $display("FAIL bp_stall: got rdw=%b acc=%b dst=%h data=%h want 1 1 90000000 a0000000",
                 rd_wait_out, access_out, dstaddr_out, data_out);
      end
    end
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 30) begin
      wr_wait_in = (cyc == 2 || cyc == 3);
      if (access_out) begin
        vec_count++;
        if (dstaddr_out !== 32'h9000_0000 + 32'(got) || data_out !== 32'hA000_0000 + 32'(got)) begin
          err_count++;
          $display("FAIL bp_order %0d: got %h/%h want %h/%h", got, dstaddr_out, data_out,
                   32'h9000_0000 + 32'(got), 32'hA000_0000 + 32'(got));
        end
        if (!wr_wait_in) got++;
      end
      acc = access_in & ~rd_wait_out;
      @(negedge eclk);
      if (acc) access_in = 1'b0;
      cyc++;
    end
    wr_wait_in = 1'b0;
    access_in  = 1'b0;
    vec_count++;
    if (got != 5) begin
      err_count++;
      $display("FAIL bp_timeout: got %0d responses want 5", got);
    end
    vec_count++;
    if (access_out !== 1'b0) begin
      err_count++;
      $display("FAIL bp_extra: got access_out=%b want 0", access_out);
    end
  endtask

  task automatic test_filter();
    put(1'b1, DM_WORD, 32'h8200_0010, 32'd0, 32'h1234_5678);
    put(1'b0, DM_WORD, 32'h8200_0010, 32'h8080_0020, 32'd0);
    vec_count++;
    if (access_out !== 1'b0) begin
      err_count++;
      $display("FAIL filter_read: got access_out=%b want 0", access_out);
    end
    put(1'b0, DM_WORD, 32'h8100_0010, 32'h8080_0020, 32'd0);
    vec_count++;
    if (access_out !== 1'b1 || data_out !== 32'hDEAD_55EF) begin
      err_count++;
      $display("FAIL filter_mem: got acc=%b data=%h want 1 dead55ef", access_out, data_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      vec_count++;
      if (rd_wait_out !== 1'b0) begin
        err_count++;
        $display("FAIL b2b_wait %0d: got rd_wait_out=%b want 0", i, rd_wait_out);
      end
      put(1'b0, DM_WORD, 32'h8100_0080 + 32'(4 * (i % 5)), 32'h7000_0000 + 32'(i), 32'd0);
      vec_count++;
      if (access_out !== 1'b1 || dstaddr_out !== 32'h7000_0000 + 32'(i) || data_out !== 32'hA000_0000 + 32'(i % 5)) begin
        err_count++;
        $display("FAIL b2b_resp %0d: got acc=%b %h/%h want 1 %h/%h", i, access_out, dstaddr_out, data_out,
                 32'h7000_0000 + 32'(i), 32'hA000_0000 + 32'(i % 5));
      end
    end
    @(negedge eclk);
  endtask

  task automatic test_mid_reset();
    logic seen;
    wr_wait_in = 1'b1;
    for (int i = 0; i < 3; i++)
      put(1'b0, DM_WORD, 32'h8100_0010, 32'h8080_0030 + 32'(i), 32'd0);
    vec_count++;
    if (access_out !== 1'b1 || dstaddr_out !== 32'h8080_0030) begin
      err_count++;
      $display("FAIL mrst_queued: got acc=%b dst=%h want 1 80800030", access_out, dstaddr_out);
    end
    reset_n = 1'b0;
    #1;
    vec_count++;
    if (access_out !== 1'b0 || wr_wait_out !== 1'b1 || rd_wait_out !== 1'b1) begin
      err_count++;
      $display("FAIL mrst_async: got acc=%b waits=%b/%b want 0 1/1", access_out, wr_wait_out, rd_wait_out);
    end
    @(negedge eclk);
    reset_n    = 1'b1;
    wr_wait_in = 1'b0;
    seen = 1'b0;
    repeat (64) begin
      @(negedge eclk);
      if (access_out) seen = 1'b1;
    end
    vec_count++;
    if (seen !== 1'b0) begin
      err_count++;
      $display("FAIL mrst_flush: got stale response want none");
    end
    vec_count++;
    if (wr_wait_out !== 1'b0 || rd_wait_out !== 1'b0) begin
      err_count++;
      $display("FAIL mrst_run: got waits=%b/%b want 0/0", wr_wait_out, rd_wait_out);
    end
    put(1'b0, DM_WORD, 32'h8100_0010, 32'h8080_0040, 32'd0);
    vec_count++;
    if (access_out !== 1'b1 || data_out !== 32'd0) begin
      err_count++;
      $display("FAIL mrst_cleared: got acc=%b data=%h want 1 0", access_out, data_out);
    end
    put(1'b0, DM_DWORD, 32'h8100_0020, 32'h8080_0040, 32'd0);
    vec_count++;
    if (data_out !== 32'd0 || srcaddr_out !== 32'd0) begin
      err_count++;
      $display("FAIL mrst_dword: got %h/%h want 0/0", data_out, srcaddr_out);
    end
    @(negedge eclk);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_dword();
    test_backpressure();
    test_filter();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/emesh_rd_responder.md
Name: emesh_rd_responder

Overview:
- Emesh-side target endpoint holding a small local register file. It consumes transactions arriving from the link and commits writes locally.
- For each read it returns one response, encoded as an emesh write transaction addressed to the requester's return address (srcaddr).
- It is the responder counterpart to the link-side initiator/arbiter path. It sits between the elink receive side and the elink transmit side.
- Responses are buffered in a FIFO with full wr_wait backpressure on the outbound side.

Parameters:
- COORD, 12'h810, dstaddr[31:20] value this block answers to; other transactions are dropped.
- AW, 6, word-address width; register file depth = 2^AW 32-bit words.
- FD, 4, response FIFO depth (power of 2, >=2).

Ports:
- eclk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- access_in  in  1  inbound transaction valid.
- write_in  in  1  1=write, 0=read request.
- datamode_in  in  2  0=byte, 1=halfword, 2=word, 3=doubleword.
- ctrlmode_in  in  4  control mode, passed through to the response.
- dstaddr_in  in  32  target address.
- srcaddr_in  in  32  read: return address; doubleword write: upper data word.
- data_in  in  32  write data, lower word.
- wr_wait_out  out  1  inbound writes must be held.
- rd_wait_out  out  1  inbound reads must be held.
- access_out  out  1  response valid.
- write_out  out  1  constant 1 while access_out.
- datamode_out  out  2  echo of the request datamode.
- ctrlmode_out  out  4  echo of the request ctrlmode.
- dstaddr_out  out  32  request srcaddr.
- srcaddr_out  out  32  doubleword: upper read word; otherwise 0.
- data_out  out  32  read data, lane-extracted, zero-extended.
- wr_wait_in  in  1  downstream stall for the response.

Behaviour:
- Reset (async assert, sync deassert): FSM=INIT, clear pointer=0, FIFO empty.
- Reset values: access_out=0, write_out=0, all payload outputs=0, wr_wait_out=1, rd_wait_out=1.
- FSM INIT:
  - writes 0 to word[clr], clr increments once per cycle.
  - at clr==2^AW-1, transitions to RUN the following cycle.
  - both waits held at 1 throughout (2^AW cycles total).
- FSM RUN: wr_wait_out=0; rd_wait_out = FIFO full (count==FD), combinational from registered count.
- Acceptance:
  - write accepted = access_in & write_in & ~wr_wait_out.
  - read accepted = access_in & ~write_in & ~rd_wait_out.
  - Unaccepted inputs are ignored; the sender holds them.
- Match: dstaddr_in[31:20]==COORD. Accepted non-matching transactions are consumed and dropped silently (no write, no response).
- Index idx = dstaddr_in[AW+1:2]. Upper offset bits are ignored (aliasing).
- Writes, committed at the accepting edge:
  - byte: byte lane dstaddr[1:0] <= data_in[7:0].
  - halfword: lane dstaddr[1] <= data_in[15:0].
  - word: word[idx] <= data_in.
  - doubleword: word[idx&~1] <= data_in, word[idx|1] <= srcaddr_in.
- Reads:
  - Read data is sampled at the accept edge, so a write committed in an earlier cycle is visible.
  - Push {srcaddr_in, ctrlmode, datamode, lo, hi} into the FIFO.
  - lo = selected lane right-aligned and zero-extended (byte/halfword), word[idx] (word), word[idx&~1] (doubleword).
  - hi = word[idx|1] for doubleword, else 0.
- Output: registered FIFO head; latency from read accept to access_out = 1 cycle when the FIFO is empty.
- access_out=1 whenever the FIFO is non-empty. Pop on access_out & ~wr_wait_in.
- While wr_wait_in=1 all outputs are held stable.
- Push and pop in the same cycle leave count unchanged and are legal even when full. No pop happens while full with wr_wait_in=1.
- Responses leave strictly in request order. No overflow or underflow is possible by construction; an assertion checks this.
- Reset mid-operation: the FIFO is flushed, in-flight responses are lost, and INIT re-clears the memory.

Decomposition:
- Shared package emesh_pkg holds:
  - datamode constants DM_BYTE/DM_HALF/DM_WORD/DM_DWORD.
  - transaction struct emesh_txn_t (write, datamode, ctrlmode, dstaddr, srcaddr, data).
  - constant COORD_W=12.
- One sub-module: emesh_sync_fifo (parameterised width/depth, count, full/empty, registered head).

Test Plan:
- Reset: release reset_n -> waits=1 for 64 cycles, then 0 on cycle 65; word-read anywhere returns data_out=0.
- Word write/read: write 0xDEADBEEF at 0x81000010, then read with srcaddr 0x80800000 -> one cycle later access_out=1, write_out=1, dstaddr_out=0x80800000, data_out=0xDEADBEEF.
- Byte and doubleword:
  - byte read at 0x81000012 returns 0x000000AD.
  - dword write {src=0x11112222, data=0x33334444} at 0x81000020, then dword read -> data_out=0x33334444, srcaddr_out=0x11112222.
- Backpressure:
  - hold wr_wait_in=1, issue 5 reads -> rd_wait_out=1 after 4; 5th held by sender.
  - release -> 5 responses in order, payload stable during each stall.
- Filtering: read and write to 0x82000010 -> no response, memory unchanged; simultaneous pop/push at full -> count stays 4, no loss.
- Reset mid-stream: assert reset_n=0 with 3 queued responses -> access_out=0 immediately, no responses after release, memory cleared.
